// File: rtl/vga_line_fetcher.sv
// Double-buffered scanline fetcher: pulls 320-word source lines from memory
// into two line buffers and serves them to a 640x480 VGA scan with 2x upscale.
module vga_line_fetcher #(
    parameter int unsigned FB_BASE = 32'h0000_0000,
    parameter int unsigned MEM_AW  = 20
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              pix_en,
    input  logic [9:0]        vga_x,
    input  logic [9:0]        vga_y,
    input  logic              enable,
    output logic              mem_rd_req,
    output logic [MEM_AW-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [15:0]       mem_rdata,
    input  logic              mem_rvalid,
    output logic [15:0]       vga_data,
    output logic              busy,
    output logic              underrun,
    output logic              overrun
);

    localparam logic [8:0] LINE_WORDS = 9'd320;

    typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;

    state_t            state_q, state_d;
    logic [8:0]        req_idx_q, req_idx_d;
    logic [8:0]        rcv_idx_q, rcv_idx_d;
    logic [7:0]        line_q, line_d;
    logic [MEM_AW-1:0] addr_q, addr_d;
    logic              underrun_q, underrun_d;
    logic              overrun_q, overrun_d;
    logic              show_q, show_d;

    logic              trigger;
    logic [7:0]        trig_line;
    logic [MEM_AW-1:0] trig_base;
    logic              visible;
    logic              wr_en;
    logic [9:0]        wr_addr;
    logic [9:0]        rd_addr;

    logic [15:0]       line_mem [0:639];
    logic [15:0]       rd_data_q;

    assign visible = pix_en && (vga_x < 10'd640) && (vga_y < 10'd480);

    // Odd visible row y prefetches source line (y+1)>>1; the last blanking row primes line 0.
    always_comb begin
        trigger   = 1'b0;
        trig_line = 8'd0;
        if (pix_en && enable && (vga_x == 10'd640)) begin
            if (vga_y[0] && (vga_y < 10'd479)) begin
                trigger   = 1'b1;
                trig_line = vga_y[8:1] + 8'd1;
            end else if (vga_y == 10'd524) begin
                trigger   = 1'b1;
            end
        end
    end

    assign trig_base = MEM_AW'(FB_BASE) + MEM_AW'(trig_line) * MEM_AW'(LINE_WORDS);

    always_comb begin
        state_d    = state_q;
        req_idx_d  = req_idx_q;
        rcv_idx_d  = rcv_idx_q;
        line_d     = line_q;
        addr_d     = addr_q;
        underrun_d = underrun_q;
        overrun_d  = overrun_q;
        show_d     = show_q;

        case (state_q)
            IDLE: begin
                if (trigger) begin
                    state_d   = FETCH;
                    line_d    = trig_line;
                    addr_d    = trig_base;
                    req_idx_d = 9'd0;
                    rcv_idx_d = 9'd0;
                end
            end
            FETCH: begin
                if (mem_ack && (req_idx_q < LINE_WORDS)) begin
                    req_idx_d = req_idx_q + 9'd1;
                    addr_d    = addr_q + MEM_AW'(1);
                end
                if (mem_rvalid && (rcv_idx_q < LINE_WORDS)) begin
                    rcv_idx_d = rcv_idx_q + 9'd1;
                    if (rcv_idx_q == LINE_WORDS - 9'd1) begin
                        state_d = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (trigger && (state_q != IDLE)) begin
            overrun_d = 1'b1;
        end
        // Row start while its own source line is still in flight: stale pixels will show.
        if (visible && (vga_x == 10'd0) && (state_q != IDLE) && ({1'b0, line_q} == vga_y[9:1])) begin
            underrun_d = 1'b1;
        end
        if (pix_en) begin
            show_d = visible && enable;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            req_idx_q  <= 9'd0;
            rcv_idx_q  <= 9'd0;
            line_q     <= 8'd0;
            addr_q     <= '0;
            underrun_q <= 1'b0;
            overrun_q  <= 1'b0;
            show_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_idx_q  <= req_idx_d;
            rcv_idx_q  <= rcv_idx_d;
            line_q     <= line_d;
            addr_q     <= addr_d;
            underrun_q <= underrun_d;
            overrun_q  <= overrun_d;
            show_q     <= show_d;
        end
    end

    // Both line buffers share one RAM: buffer 1 occupies words 320..639.
    assign wr_en   = (state_q == FETCH) && mem_rvalid && (rcv_idx_q < LINE_WORDS);
    assign wr_addr = (line_q[0] ? 10'd320 : 10'd0) + {1'b0, rcv_idx_q};
    assign rd_addr = (vga_y[1] ? 10'd320 : 10'd0) + {1'b0, vga_x[9:1]};

    always_ff @(posedge clk) begin
        if (wr_en) begin
            line_mem[wr_addr] <= mem_rdata;
        end
        if (visible) begin
            rd_data_q <= line_mem[rd_addr];
        end
    end

    assign mem_rd_req = (state_q == FETCH) && (req_idx_q < LINE_WORDS);
    assign mem_addr   = addr_q;
    assign busy       = (state_q != IDLE);
    assign underrun   = underrun_q;
    assign overrun    = overrun_q;
    // show_q gates the RAM read register so blanked or reset pixels are black.
    assign vga_data   = show_q ? rd_data_q : 16'h0000;

endmodule

// File: tb/tb_vga_line_fetcher.sv
// Scoreboard bench for vga_line_fetcher: memory model returns word = address
// after 3 cycles; expected addresses and pixels are queued as stimulus is driven.
module tb_vga_line_fetcher;

    localparam int unsigned FB = 32'h0000_0040;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        pix_en;
    logic [9:0]  vga_x;
    logic [9:0]  vga_y;
    logic        enable;
    logic        mem_rd_req;
    logic [19:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [15:0] mem_rdata = 16'h0000;
    logic        mem_rvalid = 1'b0;
    logic [15:0] vga_data;
    logic        busy;
    logic        underrun;
    logic        overrun;

    vga_line_fetcher #(.FB_BASE(FB), .MEM_AW(20)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .pix_en     (pix_en),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .enable     (enable),
        .mem_rd_req (mem_rd_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .mem_rvalid (mem_rvalid),
        .vga_data   (vga_data),
        .busy       (busy),
        .underrun   (underrun),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [15:0] exp_buf [0:1][0:319];
    logic [19:0] exp_addr_q [$];
    logic [15:0] exp_q [$];
    logic [15:0] mon_exp;

    function automatic logic [19:0] fb_addr(input int s, input int i);
        return 20'(FB + 32'(s) * 320 + 32'(i));
    endfunction

    function automatic logic [15:0] exp_pix(input int x, input int y, input logic en);
        if (!en || x >= 640 || y >= 480) return 16'h0000;
        return exp_buf[(y / 2) % 2][x / 2];
    endfunction

    task automatic push_addrs(input int s);
        for (int i = 0; i < 320; i++) exp_addr_q.push_back(fb_addr(s, i));
    endtask

    task automatic fill_line(input int s);
        logic [19:0] a;
        for (int i = 0; i < 320; i++) begin
            a = fb_addr(s, i);
            exp_buf[s % 2][i] = a[15:0];
        end
    endtask

    // Memory model: ack policy, 3-deep read pipeline, address scoreboard.
    int  cyc = 0;
    int  ack_mode = 0;
    int  acc_count = 0;
    int  run_len = 0;
    int  last_acc_cyc = -10;
    int  busy_cnt = 0;
    bit          pv [0:2];
    logic [15:0] pd [0:2];

    always @(negedge clk) begin
        cyc++;
        if (busy) busy_cnt++;
        mem_ack    = (ack_mode == 0) || (cyc % 8 == 0);
        mem_rvalid = pv[2];
        mem_rdata  = pd[2];
        pv[2] = pv[1]; pd[2] = pd[1];
        pv[1] = pv[0]; pd[1] = pd[0];
        pv[0] = mem_rd_req && mem_ack;
        pd[0] = mem_addr[15:0];
        if (pv[0]) begin
            acc_count++;
            run_len      = (last_acc_cyc == cyc - 1) ? run_len + 1 : 1;
            last_acc_cyc = cyc;
            check("req_expected", 32'(exp_addr_q.size() != 0), 1);
            if (exp_addr_q.size() != 0) check("mem_addr", mem_addr, exp_addr_q.pop_front());
        end
    end

    // Pixel monitor: one expected value per pix_en strobe, compared 1 clk later.
    always @(posedge clk) begin
        if (pix_en) begin
            #1;
            check("pix_queue", 32'(exp_q.size()), 1);
            if (exp_q.size() != 0) begin
                mon_exp = exp_q.pop_front();
                check("vga_data", vga_data, mon_exp);
                $display("pix x=%0d y=%0d en=%0b vga_data=%04h exp=%04h", vga_x, vga_y, enable, vga_data, mon_exp);
            end
        end
    end

    task automatic pix(input int x, input int y);
        logic [15:0] e;
        @(negedge clk);
        vga_x  = 10'(x);
        vga_y  = 10'(y);
        pix_en = 1'b1;
        e = exp_pix(x, y, enable);
        exp_q.push_back(e);
        @(negedge clk);
        pix_en = 1'b0;
        @(posedge clk);
        #1;
        check("vga_hold", vga_data, e);
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < budget);
        check("busy_timeout", busy, 0);
    endtask

    int a0;
    int b0;
    int n;

    initial begin
        reset_n = 1'b0;
        pix_en  = 1'b0;
        vga_x   = '0;
        vga_y   = '0;
        enable  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_req", mem_rd_req, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_vga", vga_data, 0);
        check("rst_underrun", underrun, 0);
        check("rst_overrun", overrun, 0);
        reset_n = 1'b1;
        enable  = 1'b1;
        repeat (2) @(negedge clk);

        // Line 0 from the last blanking row, ack always.
        ack_mode = 0;
        a0 = acc_count;
        b0 = busy_cnt;
        push_addrs(0);
        pix(640, 524);
        check("busy_after_trigger", busy, 1);
        wait_idle(2000);
        check("fetch0_count", acc_count - a0, 320);
        check("fetch0_consecutive", run_len, 320);
        check("fetch0_busy_cycles", busy_cnt - b0, 324);
        check("fetch0_addr_left", 32'(exp_addr_q.size()), 0);
        check("fetch0_underrun", underrun, 0);
        check("fetch0_overrun", overrun, 0);
        $display("fetch line 0 done: %0d words, busy %0d cycles", acc_count - a0, busy_cnt - b0);
        fill_line(0);
        pix(0, 0); pix(1, 0); pix(2, 0); pix(3, 0);
        pix(0, 1); pix(1, 1); pix(2, 1); pix(3, 1); pix(639, 1);

        // Line 3 from row 5 lands in buffer 1.
        a0 = acc_count;
        push_addrs(3);
        pix(640, 5);
        wait_idle(2000);
        check("fetch3_count", acc_count - a0, 320);
        $display("fetch line 3 done: %0d words", acc_count - a0);
        fill_line(3);
        pix(0, 6); pix(1, 6); pix(2, 6); pix(639, 7); pix(5, 7); pix(2, 0);
        check("fetch3_underrun", underrun, 0);

        // Blanked pixels and disabled trigger.
        pix(700, 6); pix(3, 6); pix(10, 490); pix(3, 6);
        enable = 1'b0;
        pix(2, 6);
        a0 = acc_count;
        pix(640, 5);
        repeat (10) @(negedge clk);
        check("disabled_no_req", acc_count - a0, 0);
        check("disabled_busy", busy, 0);
        $display("disabled trigger: %0d requests", acc_count - a0);
        enable = 1'b1;

        // Slow memory: underrun on row 6, overrun on a second trigger.
        ack_mode = 1;
        a0 = acc_count;
        push_addrs(3);
        pix(640, 5);
        pix(0, 0);
        check("underrun_other_line", underrun, 0);
        pix(0, 6);
        check("underrun_set", underrun, 1);
        pix(640, 524);
        check("overrun_set", overrun, 1);
        check("busy_during_slow", busy, 1);
        wait_idle(4000);
        repeat (40) @(negedge clk);
        check("slow_count", acc_count - a0, 320);
        check("slow_addr_left", 32'(exp_addr_q.size()), 0);
        $display("slow fetch line 3 done: %0d words, underrun=%0b overrun=%0b", acc_count - a0, underrun, overrun);

        // Reset at word 100 of a fetch.
        ack_mode = 0;
        a0 = acc_count;
        push_addrs(0);
        pix(640, 524);
        pix(4, 6);
        n = 0;
        while ((acc_count - a0 < 100) && (n < 1000)) begin
            @(negedge clk);
            n++;
        end
        check("reach_word100", 32'(acc_count - a0 >= 100), 1);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("midrst_req", mem_rd_req, 0);
        check("midrst_addr", mem_addr, 0);
        check("midrst_busy", busy, 0);
        check("midrst_vga", vga_data, 0);
        check("midrst_underrun", underrun, 0);
        check("midrst_overrun", overrun, 0);
        $display("reset at word %0d", acc_count - a0);
        exp_addr_q.delete();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
        check("postrst_busy", busy, 0);
        check("postrst_req", mem_rd_req, 0);
        check("postrst_underrun", underrun, 0);
        check("postrst_overrun", overrun, 0);

        a0 = acc_count;
        push_addrs(0);
        pix(640, 524);
        wait_idle(2000);
        check("refetch_count", acc_count - a0, 320);
        $display("refetch line 0 done: %0d words", acc_count - a0);
        fill_line(0);
        pix(0, 0); pix(1, 0); pix(638, 1); pix(400, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/vga_line_fetcher.md
VGA_LINE_FETCHER -- requirements
Module: vga_line_fetcher

Interface
REQ-001 Parameter FB_BASE, default 20'h00000: word address of source line 0 of the 320x240 16-bit framebuffer.
REQ-002 Parameter MEM_AW, default 20: memory word-address width.
REQ-003 clk  input  1  the single clock for the whole block; every register is clocked on its rising edge.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 pix_en  input  1  one-cycle strobe per VGA pixel period; vga_x and vga_y are valid while it is high.
REQ-006 vga_x, vga_y  input  10 each  pixel coordinates from the VGA controller; frame is 800x525, visible area 640x480.
REQ-007 enable  input  1  when low, no new fetch starts and the pixel output is black.
REQ-008 mem_rd_req  output  1  read request; held high with a stable mem_addr until mem_ack.
REQ-009 mem_addr  output  MEM_AW  word address of the pending read.
REQ-010 mem_ack  input  1  request accepted this cycle.
REQ-011 mem_rdata  input  16  read data, returned in request order.
REQ-012 mem_rvalid  input  1  mem_rdata is valid this cycle.
REQ-013 vga_data  output  16  RGB565 pixel to the colour-extend stage.
REQ-014 busy  output  1  a line fetch is in progress.
REQ-015 underrun  output  1  sticky: a line was displayed before its fetch completed.
REQ-016 overrun  output  1  sticky: a fetch trigger arrived while busy.

Function
REQ-017 Line storage: two 320x16 line buffers; source line s is written to buffer s[0].
REQ-018 Fetch trigger: a cycle with pix_en=1 and vga_x=640 and enable=1, when vga_y is odd and below 479 (fetch s=(vga_y+1)>>1) or vga_y=524 (fetch s=0); no other cycle triggers.
REQ-019 FSM states: IDLE, FETCH, DONE; IDLE->FETCH on trigger; FETCH->DONE when 320 words have been received; DONE->IDLE next cycle.
REQ-020 In FETCH, the block issues word i=0..319 at address (FB_BASE + s*320 + i) mod 2^MEM_AW; back-to-back requests are allowed, and i advances on each mem_ack.
REQ-021 mem_rd_req drops the cycle after the 320th mem_ack; the address for the next word is presented on the same cycle mem_ack is seen.
REQ-022 Each mem_rvalid writes mem_rdata to buffer s[0] at a 9-bit receive index, which increments per rvalid; rvalid in IDLE or DONE is ignored.
REQ-023 busy is high in FETCH and DONE.
REQ-024 Trigger while busy: the trigger is ignored, the current fetch continues, and overrun is set.
REQ-025 Display: on pix_en with vga_x<640 and vga_y<480, the block reads buffer (vga_y>>1)[0] at index vga_x>>1 (2x upscale); vga_data is registered and valid exactly 1 clk after the pix_en cycle.
REQ-026 vga_data is 16'h0000 for pixels outside 640x480 or when enable=0; vga_data holds between pix_en strobes.
REQ-027 underrun is set if a visible pixel of row vga_y (vga_x=0) is requested while busy and the line in flight is (vga_y>>1); stale data is shown, with no stall.
REQ-028 enable falling mid-fetch: the current fetch completes; only new triggers are blocked.
REQ-029 Counters: request index and receive index are 9 bits and saturate at 320; the multiply s*320 is computed at MEM_AW width.

Reset
REQ-030 Asserting reset_n low immediately forces: IDLE, mem_rd_req=0, mem_addr=0, vga_data=0, busy=0, underrun=0, overrun=0, all indices 0.
REQ-031 Reset mid-fetch abandons the fetch; buffer contents are undefined; mem_rvalid arriving after release is ignored until the next trigger.
REQ-032 After release, the first fetch starts at the next valid trigger.

Verification
REQ-033 Memory model with ack always 1 and 3-cycle read latency, vga_y=524, vga_x=640 strobe -> addresses FB_BASE..FB_BASE+319 issued on consecutive cycles; busy falls about 324 cycles later; buffer 0 is filled.
REQ-034 Framebuffer word = address; display rows 0-1, vga_x=0..3 -> vga_data 0,0,1,1 (row 0 and row 1 identical), each 1 clk after pix_en.
REQ-035 Trigger at vga_y=5 -> s=3; first mem_addr=FB_BASE+960; data lands in buffer 1; row 6 shows it.
REQ-036 Memory model with ack every 8th cycle and a second trigger while busy -> overrun=1 and the fetch count stays 320; with vga_y=6 reached before completion, underrun=1.
REQ-037 vga_x=700 or vga_y=490, or enable=0 -> vga_data=0; trigger with enable=0 -> no mem_rd_req.
REQ-038 reset_n pulsed low at word 100 of a fetch -> all outputs are 0 within the same cycle; late rvalid pulses do not write or advance indices; the next trigger fetches normally.
